sys_bus_router: RTL and testbench

// - Routes the LSU-side data memory request to one of N_SLAVES memory-mapped targets
//   (data_mem, timer, uart, ...), selected by address region bits.
// - Sits between lsu and the slaves in processor_system, replacing the point-to-point lsu<->data_mem link.
// - Holds each request until the selected slave's ready, returns read data, flags unmapped accesses.

---
 rtl/sys_bus_router.sv | 168 ++++++++++++++++
 tb/tb_sys_bus_router.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_router.sv
// Routes one LSU data request at a time to a memory-mapped slave selected by address region bits.
// Define BUS_TIMEOUT_EN to abort slave accesses that stall for TIMEOUT_CYCLES cycles.
module sys_bus_router #(
  parameter int unsigned N_SLAVES       = 4,
  parameter int unsigned SEL_MSB        = 31,
  parameter int unsigned SEL_LSB        = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wd_i,
  output logic [31:0]              rd_o,
  output logic                     ready_o,
  output logic                     err_o,
  output logic [N_SLAVES-1:0]      m_req_o,
  output logic                     m_we_o,
  output logic [3:0]               m_be_o,
  output logic [31:0]              m_addr_o,
  output logic [31:0]              m_wd_o,
  input  logic [32*N_SLAVES-1:0]   m_rd_i,
  input  logic [N_SLAVES-1:0]      m_ready_i
);

  localparam int unsigned SelW = SEL_MSB - SEL_LSB + 1;
  // Region-select bits are stripped so each slave sees a local address.
  localparam logic [31:0] SelMask = ((32'd1 << SelW) - 32'd1) << SEL_LSB;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              r_state, w_state_nxt;
  logic [SelW-1:0]     r_sel;
  logic                r_we;
  logic [3:0]          r_be;
  logic [31:0]         r_addr;
  logic [31:0]         r_wd;
  logic [N_SLAVES-1:0] r_m_req, w_m_req_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_err, w_err_nxt;
  logic [31:0]         r_rd, w_rd_nxt;

  logic [SelW-1:0]     w_sel_in;
  logic                w_mapped;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_latch;
  logic                w_slv_ready;
  logic [31:0]         w_slv_rd;
  logic                w_timeout;

  assign w_sel_in = addr_i[SEL_MSB:SEL_LSB];
  assign w_mapped = 32'(w_sel_in) < N_SLAVES;

  always_comb begin
    w_onehot    = '0;
    w_slv_ready = 1'b0;
    w_slv_rd    = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      w_onehot[k] = (32'(w_sel_in) == k);
      if (32'(r_sel) == k) begin
        w_slv_ready = m_ready_i[k];
        w_slv_rd    = m_rd_i[32*k +: 32];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] r_cnt;

  assign w_timeout = (r_state == StAccess) && !w_slv_ready &&
                     (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state != StAccess) begin
      r_cnt <= '0;
    end else if (!w_slv_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_m_req_nxt = '0;
    w_ready_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_nxt    = '0;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_latch = 1'b1;
          if (w_mapped) begin
            w_state_nxt = StAccess;
            w_m_req_nxt = w_onehot;
          end else begin
            w_state_nxt = StResp;
            w_ready_nxt = 1'b1;
            w_err_nxt   = 1'b1;
          end
        end
      end
      StAccess: begin
        if (w_slv_ready) begin
          w_state_nxt = StResp;
          w_ready_nxt = 1'b1;
          w_rd_nxt    = r_we ? 32'd0 : w_slv_rd;
        end else if (w_timeout) begin
          w_state_nxt = StResp;
          w_ready_nxt = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
          w_m_req_nxt = r_m_req;
        end
      end
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wd    <= '0;
      r_m_req <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_m_req <= w_m_req_nxt;
      r_ready <= w_ready_nxt;
      r_err   <= w_err_nxt;
      r_rd    <= w_rd_nxt;
      if (w_latch) begin
        r_sel  <= w_sel_in;
        r_we   <= we_i;
        r_be   <= be_i;
        r_addr <= addr_i & ~SelMask;
        r_wd   <= wd_i;
      end
    end
  end

  assign rd_o     = r_rd;
  assign ready_o  = r_ready;
  assign err_o    = r_err;
  assign m_req_o  = r_m_req;
  assign m_we_o   = r_we;
  assign m_be_o   = r_be;
  assign m_addr_o = r_addr;
  assign m_wd_o   = r_wd;

endmodule

// File: tb/tb_sys_bus_router.sv
// Directed bench for sys_bus_router with a response scoreboard; honours BUS_TIMEOUT_EN.
module tb_sys_bus_router;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned Timeout = 8;
`else
  localparam int unsigned Timeout = 255;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         req_i = 1'b0;
  logic         we_i = 1'b0;
  logic [3:0]   be_i = '0;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wd_i = '0;
  logic [31:0]  rd_o;
  logic         ready_o;
  logic         err_o;
  logic [3:0]   m_req_o;
  logic         m_we_o;
  logic [3:0]   m_be_o;
  logic [31:0]  m_addr_o;
  logic [31:0]  m_wd_o;
  logic [127:0] m_rd_i;
  logic [3:0]   m_ready_i = '0;

  logic [31:0] slv_data [4] = '{32'h1111_A000, 32'h2222_B001, 32'h3333_C002, 32'h4444_D003};

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } resp_t;
  resp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  assign m_rd_i = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

  always #5 clk_i = ~clk_i;

  sys_bus_router #(
    .N_SLAVES       (4),
    .SEL_MSB        (31),
    .SEL_LSB        (24),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wd_i      (wd_i),
    .rd_o      (rd_o),
    .ready_o   (ready_o),
    .err_o     (err_o),
    .m_req_o   (m_req_o),
    .m_we_o    (m_we_o),
    .m_be_o    (m_be_o),
    .m_addr_o  (m_addr_o),
    .m_wd_o    (m_wd_o),
    .m_rd_i    (m_rd_i),
    .m_ready_i (m_ready_i)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called in the cycle ready_o is expected; pops the oldest expected response.
  task automatic check_resp(input string tag);
    resp_t e;
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, "_sb"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rd"}, rd_o, e.rd);
      chk({tag, "_err"}, {31'd0, err_o}, {31'd0, e.err});
    end
    chk({tag, "_mreq_off"}, {28'd0, m_req_o}, 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wd, input int waits,
                         input logic [3:0] exp_req, input logic [3:0] noise);
    int k;
    resp_t e;
    k = int'(addr[31:24]);
    e.err = (k >= 4);
    e.rd  = (we || e.err) ? 32'd0 : slv_data[k];
    sb_q.push_back(e);
    req_i  = 1'b1;
    we_i   = we;
    be_i   = be;
    addr_i = addr;
    wd_i   = wd;
    step();
    if (exp_req != 4'd0) begin
      for (int w = 0; w <= waits; w++) begin
        chk({tag, "_mreq"}, {28'd0, m_req_o}, {28'd0, exp_req});
        chk({tag, "_maddr"}, m_addr_o, addr & 32'h00FF_FFFF);
        chk({tag, "_mwd"}, m_wd_o, wd);
        chk({tag, "_mbe_we"}, {27'd0, m_we_o, m_be_o}, {27'd0, we, be});
        chk({tag, "_ready_low"}, {31'd0, ready_o}, 32'd0);
        m_ready_i = (w == waits) ? exp_req : noise;
        step();
      end
      m_ready_i = '0;
    end
    check_resp(tag);
    req_i = 1'b0;
    step();
    chk({tag, "_pulse_end"}, {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    step();
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_mreq", {28'd0, m_req_o}, 32'd0);
    chk("rst_rd", rd_o, 32'd0);
    chk("rst_maddr", m_addr_o, 32'd0);
    rst_i = 1'b0;
    step();

    run_txn("rd_s0", 32'h0000_0010, 1'b0, 4'hF, 32'd0, 0, 4'b0001, 4'b0000);
    run_txn("wr_s2", 32'h0200_0004, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 4'b0100, 4'b0000);
    run_txn("unmap", 32'h0700_0000, 1'b0, 4'hF, 32'd0, 0, 4'b0000, 4'b0000);
    run_txn("rd_s3", 32'h0300_0ABC, 1'b0, 4'hF, 32'd0, 2, 4'b1000, 4'b0010);
    run_txn("rd_s1", 32'h0100_0100, 1'b0, 4'hF, 32'd0, 1, 4'b0010, 4'b1101);

    // Reset in the middle of an access.
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0100_0020;
    step();
    chk("rstmid_mreq_pre", {28'd0, m_req_o}, 32'd2);
    step();
    #2;
    rst_i = 1'b1;
    #1;
    chk("rstmid_mreq", {28'd0, m_req_o}, 32'd0);
    chk("rstmid_ready", {31'd0, ready_o}, 32'd0);
    req_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    chk("rstmid_idle_mreq", {28'd0, m_req_o}, 32'd0);
    chk("rstmid_maddr", m_addr_o, 32'd0);
    run_txn("post_rst", 32'h0000_0040, 1'b0, 4'hF, 32'd0, 0, 4'b0001, 4'b0000);

`ifdef BUS_TIMEOUT_EN
    begin
      resp_t e;
      e.rd  = 32'd0;
      e.err = 1'b1;
      sb_q.push_back(e);
      req_i  = 1'b1;
      addr_i = 32'h0200_0008;
      step();
      for (int i = 0; i < 8; i++) begin
        chk("tmo_mreq", {28'd0, m_req_o}, 32'd4);
        step();
      end
      check_resp("tmo");
      req_i = 1'b0;
      step();
    end
`else
    begin
      int held = 0;
      req_i  = 1'b1;
      addr_i = 32'h0200_0008;
      step();
      for (int i = 0; i < 110; i++) begin
        if (m_req_o == 4'b0100 && !ready_o) held++;
        step();
      end
      chk("hold_cycles", held, 32'd110);
      req_i = 1'b0;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      step();
    end
`endif

    run_txn("final_rd", 32'h0300_0000, 1'b0, 4'hF, 32'd0, 0, 4'b1000, 4'b0000);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
